// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared definitions for the kitchen game. Holds the round-state
//            encoding, the order slot count, the empty-slot time value and
//            the score width. game_logic and the display decode these values.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } round_state_t;

    localparam int              c_num_slots  = 4;
    localparam int              c_idx_w      = 2;
    localparam int              c_time_w     = 5;
    localparam logic [4:0]      c_empty_time = 5'd31;
    localparam int              c_score_w    = 10;
    localparam int              c_score_max  = 1023;

endpackage

`default_nettype wire

// File: rtl/order_slot_select.sv
`default_nettype none
// ============================================================================
// Module   : order_slot_select
// Purpose  : Combinational slot picker for the order scheduler.
// Ports    : i_valid      - current valid bit per slot
//            i_times      - packed remaining time per slot (slot i at [5i+:5])
//            i_occupied   - slot occupancy used for the free-slot search
//            o_oldest_idx - valid slot with the smallest remaining time
//                           (ties go to the lowest index)
//            o_any_valid  - at least one slot in i_valid is set
//            o_free_idx   - lowest index whose i_occupied bit is clear
//            o_any_free   - at least one slot in i_occupied is clear
// Revision : 1.0 - initial release
// ============================================================================
module order_slot_select
    import game_pkg::*;
(
    input  logic [c_num_slots-1:0]          i_valid,
    input  logic [c_num_slots*c_time_w-1:0] i_times,
    input  logic [c_num_slots-1:0]          i_occupied,
    output logic [c_idx_w-1:0]              o_oldest_idx,
    output logic                            o_any_valid,
    output logic [c_idx_w-1:0]              o_free_idx,
    output logic                            o_any_free
);

    logic [c_time_w-1:0] w_best_time;

    // "Oldest" means closest to expiry. The strict less-than keeps the
    // earlier (lower) index on a tie.
    always_comb begin
        o_oldest_idx = '0;
        o_any_valid  = 1'b0;
        w_best_time  = c_empty_time;
        for (int i = 0; i < c_num_slots; i++) begin
            if (i_valid[i] && (!o_any_valid || (i_times[i*c_time_w +: c_time_w] < w_best_time))) begin
                o_oldest_idx = c_idx_w'(i);
                w_best_time  = i_times[i*c_time_w +: c_time_w];
                o_any_valid  = 1'b1;
            end
        end
    end

    // Kept in its own process: the occupancy input is derived from the
    // oldest-slot result, so sharing one block would form a false loop.
    always_comb begin
        o_free_idx = '0;
        o_any_free = 1'b0;
        for (int i = c_num_slots - 1; i >= 0; i--) begin
            if (!i_occupied[i]) begin
                o_free_idx = c_idx_w'(i);
                o_any_free = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/order_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : order_scheduler
// Purpose  : Round timer, order spawner/expirer and scorer for the kitchen
//            game. Four order slots count down once per second. A submit
//            serves the order closest to expiry. Expired orders cost points.
// Ports    : clock, reset   - system clock, synchronous active-high reset
//            i_sec_tick     - one-cycle pulse per second
//            i_start        - starts a round from IDLE or DONE
//            i_pause        - level; freezes a running round
//            i_submit       - one-cycle pulse; a dish was delivered
//            o_orders       - valid bit per slot
//            o_order_times  - 5 bits per slot (slot i at [5i+:5]), 31 = empty
//            o_time_left    - round seconds remaining
//            o_point_total  - score
//            o_submit_ack   - pulse one cycle after i_submit
//            o_submit_hit   - with ack: an order was served
//            o_round_state  - IDLE=0 RUN=1 PAUSED=2 DONE=3
// Revision : 1.0 - initial release
// ============================================================================
module order_scheduler
    import game_pkg::*;
#(
    parameter int GAME_SECONDS   = 150,
    parameter int ORDER_LIFE     = 30,
    parameter int SPAWN_PERIOD   = 20,
    parameter int SERVE_POINTS   = 20,
    parameter int EXPIRE_PENALTY = 10
)(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            i_sec_tick,
    input  logic                            i_start,
    input  logic                            i_pause,
    input  logic                            i_submit,
    output logic [c_num_slots-1:0]          o_orders,
    output logic [c_num_slots*c_time_w-1:0] o_order_times,
    output logic [7:0]                      o_time_left,
    output logic [c_score_w-1:0]            o_point_total,
    output logic                            o_submit_ack,
    output logic                            o_submit_hit,
    output logic [1:0]                      o_round_state
);

    localparam logic [7:0]          c_game_secs = 8'(GAME_SECONDS);
    localparam logic [7:0]          c_spawn_per = 8'(SPAWN_PERIOD);
    localparam logic [c_time_w-1:0] c_life      = c_time_w'(ORDER_LIFE);

    // Registered state
    round_state_t           r_state;
    logic [c_num_slots-1:0] r_valid;
    logic [c_time_w-1:0]    r_time [c_num_slots];
    logic [7:0]             r_time_left;
    logic [7:0]             r_spawn_cnt;
    logic [c_score_w-1:0]   r_score;
    logic                   r_ack;
    logic                   r_hit;

    // Next-state values
    round_state_t           w_state_nxt;
    logic [c_num_slots-1:0] w_valid_nxt;
    logic [c_time_w-1:0]    w_time_nxt [c_num_slots];
    logic [7:0]             w_time_left_nxt;
    logic [7:0]             w_spawn_nxt;
    logic [c_score_w-1:0]   w_score_nxt;
    logic                   w_hit_nxt;

    // Serve/tick stage results
    logic                   w_run_active;
    logic                   w_serve;
    logic                   w_tick;
    logic [c_num_slots-1:0] w_valid_post;
    logic [c_num_slots-1:0] w_expired;
    logic [c_time_w-1:0]    w_time_post [c_num_slots];
    logic [2:0]             w_n_exp;
    logic [15:0]            w_sum;
    logic [15:0]            w_served_score;
    logic [15:0]            w_penalty;
    logic [c_score_w-1:0]   w_score_post;

    // Slot selection
    logic [c_num_slots*c_time_w-1:0] w_times_packed;
    logic [c_idx_w-1:0]     w_oldest_idx;
    logic                   w_any_valid;
    logic [c_idx_w-1:0]     w_free_idx;
    logic                   w_any_free;

    for (genvar g = 0; g < c_num_slots; g++) begin : g_pack
        assign w_times_packed[g*c_time_w +: c_time_w] = r_time[g];
    end

    // Free-slot search runs on the post-serve, post-expiry occupancy so a
    // slot vacated this tick is immediately reusable by a spawn.
    order_slot_select u_select (
        .i_valid      (r_valid),
        .i_times      (w_times_packed),
        .i_occupied   (w_valid_post),
        .o_oldest_idx (w_oldest_idx),
        .o_any_valid  (w_any_valid),
        .o_free_idx   (w_free_idx),
        .o_any_free   (w_any_free)
    );

    assign w_run_active = (r_state == ST_RUN) && !i_pause;
    assign w_serve      = w_run_active && i_submit && w_any_valid;
    assign w_tick       = w_run_active && i_sec_tick;

    // The serve is resolved on pre-tick times. The served slot is vacated
    // first, so the tick neither decrements nor expires it.
    always_comb begin
        w_valid_post = r_valid;
        w_expired    = '0;
        for (int i = 0; i < c_num_slots; i++) begin
            w_time_post[i] = r_time[i];
            if (w_serve && (w_oldest_idx == c_idx_w'(i))) begin
                w_valid_post[i] = 1'b0;
                w_time_post[i]  = c_empty_time;
            end else if (w_tick && r_valid[i]) begin
                if (r_time[i] == c_time_w'(1)) begin
                    w_expired[i]    = 1'b1;
                    w_valid_post[i] = 1'b0;
                    w_time_post[i]  = c_empty_time;
                end else begin
                    w_time_post[i] = r_time[i] - c_time_w'(1);
                end
            end
        end
    end

    // Score: serve credit saturates high first, then the expiry penalties
    // saturate low. All penalties are summed because each expiry counts.
    always_comb begin
        w_sum          = 16'(r_score);
        if (w_serve) begin
            w_sum = 16'(r_score) + 16'(SERVE_POINTS) + 16'(r_time[w_oldest_idx]);
        end
        w_served_score = (w_sum > 16'(c_score_max)) ? 16'(c_score_max) : w_sum;
        w_n_exp        = 3'($countones(w_expired));
        w_penalty      = 16'(w_n_exp) * 16'(EXPIRE_PENALTY);
        w_score_post   = (w_served_score > w_penalty) ?
                         c_score_w'(w_served_score - w_penalty) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_valid;
        w_time_nxt      = r_time;
        w_time_left_nxt = r_time_left;
        w_spawn_nxt     = r_spawn_cnt;
        w_score_nxt     = r_score;
        w_hit_nxt       = w_serve;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt     = ST_RUN;
                    w_time_left_nxt = c_game_secs;
                    w_score_nxt     = '0;
                    w_spawn_nxt     = c_spawn_per;
                    w_valid_nxt     = c_num_slots'(1);
                    for (int i = 0; i < c_num_slots; i++) begin
                        w_time_nxt[i] = c_empty_time;
                    end
                    w_time_nxt[0]   = c_life;
                end
            end

            ST_RUN: begin
                if (i_pause) begin
                    w_state_nxt = ST_PAUSED;
                end else begin
                    w_valid_nxt = w_valid_post;
                    w_time_nxt  = w_time_post;
                    w_score_nxt = w_score_post;
                    if (w_tick) begin
                        w_time_left_nxt = r_time_left - 8'd1;
                        if (r_spawn_cnt == 8'd1) begin
                            w_spawn_nxt = c_spawn_per;
                            if (w_any_free) begin
                                w_valid_nxt[w_free_idx] = 1'b1;
                                w_time_nxt[w_free_idx]  = c_life;
                            end
                        end else begin
                            w_spawn_nxt = r_spawn_cnt - 8'd1;
                        end
                        // Final second: the score keeps this tick's effects,
                        // the board is wiped.
                        if (r_time_left == 8'd1) begin
                            w_state_nxt = ST_DONE;
                            w_valid_nxt = '0;
                            for (int i = 0; i < c_num_slots; i++) begin
                                w_time_nxt[i] = c_empty_time;
                            end
                        end
                    end
                end
            end

            ST_PAUSED: begin
                if (!i_pause) begin
                    w_state_nxt = ST_RUN;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= '0;
            for (int i = 0; i < c_num_slots; i++) begin
                r_time[i] <= c_empty_time;
            end
            r_time_left <= c_game_secs;
            r_spawn_cnt <= c_spawn_per;
            r_score     <= '0;
            r_ack       <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_time      <= w_time_nxt;
            r_time_left <= w_time_left_nxt;
            r_spawn_cnt <= w_spawn_nxt;
            r_score     <= w_score_nxt;
            r_ack       <= i_submit;
            r_hit       <= w_hit_nxt;
        end
    end

    assign o_orders      = r_valid;
    assign o_order_times = w_times_packed;
    assign o_time_left   = r_time_left;
    assign o_point_total = r_score;
    assign o_submit_ack  = r_ack;
    assign o_submit_hit  = r_hit;
    assign o_round_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_scheduler
// Purpose  : Self-checking bench for order_scheduler: a table of scripted
//            cycles with hand-derived expectations, a mid-round reset, then
//            random stimulus against a behavioural model of the game rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_scheduler;

    localparam int GAME = 150;
    localparam int LIFE = 30;
    localparam int SPER = 20;
    localparam int SPTS = 20;
    localparam int PEN  = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_sec_tick, i_start, i_pause, i_submit;
    logic [3:0]  o_orders;
    logic [19:0] o_order_times;
    logic [7:0]  o_time_left;
    logic [9:0]  o_point_total;
    logic        o_submit_ack, o_submit_hit;
    logic [1:0]  o_round_state;

    always #5 clock = ~clock;

    order_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .i_sec_tick    (i_sec_tick),
        .i_start       (i_start),
        .i_pause       (i_pause),
        .i_submit      (i_submit),
        .o_orders      (o_orders),
        .o_order_times (o_order_times),
        .o_time_left   (o_time_left),
        .o_point_total (o_point_total),
        .o_submit_ack  (o_submit_ack),
        .o_submit_hit  (o_submit_hit),
        .o_round_state (o_round_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the game rules ----------------
    int m_state, m_tl, m_score, m_spawn;
    int m_time [4];
    bit m_valid [4];
    bit m_ack, m_hit;

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_time[i]  = 31;
        end
    endfunction

    function automatic void m_reset();
        m_state = 0; m_tl = GAME; m_score = 0; m_spawn = SPER;
        m_ack = 0; m_hit = 0;
        m_clear();
    endfunction

    function automatic void m_step(input bit s, input bit p, input bit sub, input bit t);
        int best;
        m_ack = sub;
        m_hit = 0;
        case (m_state)
            0, 3: if (s) begin
                m_state = 1; m_tl = GAME; m_score = 0; m_spawn = SPER;
                m_clear();
                m_valid[0] = 1; m_time[0] = LIFE;
            end
            2: if (!p) m_state = 1;
            default: begin
                if (p) begin
                    m_state = 2;
                end else begin
                    if (sub) begin
                        best = -1;
                        for (int i = 0; i < 4; i++)
                            if (m_valid[i] && (best < 0 || m_time[i] < m_time[best])) best = i;
                        if (best >= 0) begin
                            m_score = m_score + SPTS + m_time[best];
                            if (m_score > 1023) m_score = 1023;
                            m_valid[best] = 0; m_time[best] = 31;
                            m_hit = 1;
                        end
                    end
                    if (t) begin
                        for (int i = 0; i < 4; i++) begin
                            if (m_valid[i]) begin
                                if (m_time[i] == 1) begin
                                    m_valid[i] = 0; m_time[i] = 31;
                                    m_score = (m_score > PEN) ? m_score - PEN : 0;
                                end else begin
                                    m_time[i]--;
                                end
                            end
                        end
                        m_tl--;
                        if (m_spawn == 1) begin
                            m_spawn = SPER;
                            best = -1;
                            for (int i = 3; i >= 0; i--) if (!m_valid[i]) best = i;
                            if (best >= 0) begin
                                m_valid[best] = 1; m_time[best] = LIFE;
                            end
                        end else begin
                            m_spawn--;
                        end
                        if (m_tl == 0) begin
                            m_state = 3;
                            m_clear();
                        end
                    end
                end
            end
        endcase
    endfunction

    task automatic check_model(input string tag);
        int ord;
        ord = 0;
        for (int i = 0; i < 4; i++) if (m_valid[i]) ord |= (1 << i);
        chk({tag, " state"}, int'(o_round_state), m_state);
        chk({tag, " orders"}, int'(o_orders), ord);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s time%0d", tag, i), int'(o_order_times[i*5 +: 5]), m_time[i]);
        chk({tag, " time_left"}, int'(o_time_left), m_tl);
        chk({tag, " score"}, int'(o_point_total), m_score);
        chk({tag, " ack"}, int'(o_submit_ack), int'(m_ack));
        chk({tag, " hit"}, int'(o_submit_hit), int'(m_hit));
    endtask

    // One clock: drive inputs, take the edge, step the model, compare #1 later.
    task automatic cyc(input bit r, input bit s, input bit p, input bit sub, input bit t,
                       input string tag);
        reset = r; i_start = s; i_pause = p; i_submit = sub; i_sec_tick = t;
        @(posedge clock);
        #1;
        if (r) m_reset();
        else   m_step(s, p, sub, t);
        check_model(tag);
    endtask

    // ---------------- scripted vector table ----------------
    typedef struct {
        int reps;
        bit s, p, sub, t;
        int st, ord, tl, sc, t0, t1, ack, hit;
    } vec_t;

    vec_t tbl [$];

    initial begin
        bit pz;
        reset = 1; i_start = 0; i_pause = 0; i_submit = 0; i_sec_tick = 0;

        //          reps s p sb t   st ord  tl  sc  t0  t1 ack hit
        tbl.push_back('{ 1, 1,0,0,0,  1, 1, 150,  0, 30, 31, 0, 0}); // start
        tbl.push_back('{ 1, 0,0,0,1,  1, 1, 149,  0, 29, 31, 0, 0}); // first tick
        tbl.push_back('{19, 0,0,0,1,  1, 3, 130,  0, 10, 30, 0, 0}); // 2nd spawn
        tbl.push_back('{10, 0,0,0,1,  1, 2, 120,  0, 31, 20, 0, 0}); // expiry, score floor
        tbl.push_back('{ 1, 0,0,1,0,  1, 0, 120, 40, 31, 31, 1, 1}); // serve slot 1
        tbl.push_back('{ 1, 0,0,1,0,  1, 0, 120, 40, 31, 31, 1, 0}); // submit, empty
        tbl.push_back('{ 1, 0,1,0,1,  2, 0, 120, 40, 31, 31, 0, 0}); // pause
        tbl.push_back('{10, 0,1,1,1,  2, 0, 120, 40, 31, 31, 1, 0}); // frozen
        tbl.push_back('{ 1, 0,0,0,1,  1, 0, 120, 40, 31, 31, 0, 0}); // resume, tick ignored
        tbl.push_back('{ 1, 1,0,0,0,  1, 0, 120, 40, 31, 31, 0, 0}); // start ignored in RUN
        tbl.push_back('{10, 0,0,0,1,  1, 1, 110, 40, 30, 31, 0, 0}); // spawn into slot 0
        tbl.push_back('{29, 0,0,0,1,  1, 3,  81, 40,  1, 21, 0, 0}); // slot 0 at 1
        tbl.push_back('{ 1, 0,0,1,1,  1, 2,  80, 61, 31, 20, 1, 1}); // serve on tick, no penalty
        tbl.push_back('{80, 0,0,0,1,  3, 0,   0, 21, 31, 31, 0, 0}); // round ends
        tbl.push_back('{ 1, 0,0,1,1,  3, 0,   0, 21, 31, 31, 1, 0}); // DONE ignores inputs
        tbl.push_back('{ 1, 1,0,0,0,  1, 1, 150,  0, 30, 31, 0, 0}); // restart

        // Reset state against fixed values
        cyc(1, 0, 0, 0, 0, "reset");
        chk("reset state", int'(o_round_state), 0);
        chk("reset orders", int'(o_orders), 0);
        chk("reset times", int'(o_order_times), 20'hFFFFF);
        chk("reset time_left", int'(o_time_left), GAME);
        chk("reset score", int'(o_point_total), 0);

        for (int k = 0; k < tbl.size(); k++) begin
            for (int n = 0; n < tbl[k].reps; n++)
                cyc(0, tbl[k].s, tbl[k].p, tbl[k].sub, tbl[k].t, $sformatf("row%0d", k));
            chk($sformatf("row%0d state", k), int'(o_round_state), tbl[k].st);
            chk($sformatf("row%0d orders", k), int'(o_orders), tbl[k].ord);
            chk($sformatf("row%0d time_left", k), int'(o_time_left), tbl[k].tl);
            chk($sformatf("row%0d score", k), int'(o_point_total), tbl[k].sc);
            chk($sformatf("row%0d t0", k), int'(o_order_times[4:0]), tbl[k].t0);
            chk($sformatf("row%0d t1", k), int'(o_order_times[9:5]), tbl[k].t1);
            chk($sformatf("row%0d ack", k), int'(o_submit_ack), tbl[k].ack);
            chk($sformatf("row%0d hit", k), int'(o_submit_hit), tbl[k].hit);
        end

        // Mid-round reset abandons the round and the score
        for (int n = 0; n < 5; n++) cyc(0, 0, 0, 0, 1, "pre-reset");
        cyc(0, 0, 0, 1, 0, "pre-reset serve");
        chk("pre-reset score", int'(o_point_total), SPTS + LIFE - 5);
        cyc(1, 1, 0, 1, 1, "midreset");
        chk("midreset state", int'(o_round_state), 0);
        chk("midreset score", int'(o_point_total), 0);
        chk("midreset ack", int'(o_submit_ack), 0);
        chk("midreset time_left", int'(o_time_left), GAME);

        // Random phase against the model
        pz = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 24) == 0) pz = ~pz;
            cyc(($urandom_range(0, 1499) == 0),
                ($urandom_range(0, 59) == 0),
                pz,
                ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 2) == 0),
                "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
